// File: rtl/sar_search.sv
// Successive-approximation search engine: binary-searches 0..2^WIDTH-1 by issuing
// guesses to an external responder that answers less/equal/greater per guess.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   probes
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [WIDTH:0] ZERO_B = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] ONE_B  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MAX_B  = {1'b0, {WIDTH{1'b1}}};

  // Bounds are WIDTH+1 bits wide, so lo+hi and guess+1 never wrap.
  function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    return WIDTH'((a + b) >> 1);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH:0]   lo_r, lo_s, hi_r, hi_s;
  logic [WIDTH-1:0] guess_r, guess_s, result_r, result_s;
  logic [WIDTH:0]   probes_r, probes_s;
  logic             found_r, found_s, error_r, error_s;
  logic [WIDTH:0]   guess_ext_s, lo_up_s, hi_dn_s;
  logic             legal_s;

  assign guess_ext_s = {1'b0, guess_r};
  assign lo_up_s     = guess_ext_s + ONE_B;
  assign hi_dn_s     = guess_ext_s - ONE_B;
  assign legal_s     = ({less, equal, greater} == 3'b100) ||
                       ({less, equal, greater} == 3'b010) ||
                       ({less, equal, greater} == 3'b001);

  // Next-state and next-datapath decision.
  always_comb begin
    state_s  = state_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    guess_s  = guess_r;
    result_s = result_r;
    probes_s = probes_r;
    found_s  = found_r;
    error_s  = error_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s  = PROBE;
          lo_s     = ZERO_B;
          hi_s     = MAX_B;
          guess_s  = mid_of(ZERO_B, MAX_B);
          result_s = {WIDTH{1'b0}};
          probes_s = ZERO_B;
          found_s  = 1'b0;
          error_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      PROBE: begin
        if (resp_valid) begin
          probes_s = probes_r + ONE_B;
          if (!legal_s) begin
            state_s = DONE;
            error_s = 1'b1;
          end else if (equal) begin
            state_s  = DONE;
            result_s = guess_r;
            found_s  = 1'b1;
          end else if (less) begin
            lo_s = lo_up_s;
            if (lo_up_s > hi_r) begin
              state_s = DONE;
            end else begin
              guess_s = mid_of(lo_up_s, hi_r);
            end
          end else begin
            // Greater at the low bound means the target is below the range.
            if (guess_ext_s == lo_r) begin
              state_s = DONE;
            end else begin
              hi_s    = hi_dn_s;
              guess_s = mid_of(lo_r, hi_dn_s);
            end
          end
        end else begin
          state_s = PROBE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      lo_r     <= ZERO_B;
      hi_r     <= MAX_B;
      guess_r  <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      probes_r <= ZERO_B;
      found_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      guess_r  <= guess_s;
      result_r <= result_s;
      probes_r <= probes_s;
      found_r  <= found_s;
      error_r  <= error_s;
    end
  end

  assign guess       = guess_r;
  assign guess_valid = (state_r == PROBE);
  assign busy        = (state_r == PROBE);
  assign done        = (state_r == DONE);
  assign found       = found_r;
  assign error       = error_r;
  assign result      = result_r;
  assign probes      = probes_r;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=4) with a same-cycle comparator responder.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst, start, resp_valid;
  logic       less, equal, greater;
  logic [3:0] guess, result;
  logic       guess_valid, busy, done, found, error;
  logic [4:0] probes;

  logic [3:0] target;
  int         mode;  // 0 comparator, 1 always less, 2 always greater, 3 less+greater
  int         n_vec = 0;
  int         n_err = 0;

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .less(less), .equal(equal), .greater(greater),
    .guess(guess), .guess_valid(guess_valid), .busy(busy), .done(done),
    .found(found), .error(error), .result(result), .probes(probes)
  );

  always #5 clk = ~clk;

  assign less    = (mode == 0) ? (guess < target) : (mode == 1 || mode == 3);
  assign equal   = (mode == 0) ? (guess == target) : 1'b0;
  assign greater = (mode == 0) ? (guess > target) : (mode == 2 || mode == 3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs a full search; exp_g holds expected guesses as nibbles, first guess most significant.
  task automatic run_search(input string tag, input logic [3:0] tgt, input int md,
                            input logic [31:0] exp_g, input int exp_n,
                            input logic exp_found, input logic exp_error,
                            input logic [3:0] exp_result);
    int n = 0;
    logic [3:0] e;
    target = tgt;
    mode = md;
    resp_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) break;
      if (guess_valid) begin
        if (n < exp_n) begin
          e = exp_g[4*(exp_n-1-n) +: 4];
          check($sformatf("%s guess%0d", tag, n), 32'(guess), 32'(e));
        end
        n++;
      end
      @(negedge clk);
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " nguess"}, 32'(n), 32'(exp_n));
    check({tag, " found"}, 32'(found), 32'(exp_found));
    check({tag, " error"}, 32'(error), 32'(exp_error));
    check({tag, " probes"}, 32'(probes), 32'(exp_n));
    check({tag, " busy"}, 32'(busy), 32'd0);
    if (exp_found) check({tag, " result"}, 32'(result), 32'(exp_result));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " guess"}, 32'(guess), 32'd0);
    check({tag, " gvalid"}, 32'(guess_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " found"}, 32'(found), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " result"}, 32'(result), 32'd0);
    check({tag, " probes"}, 32'(probes), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; target = 4'd0; mode = 0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_search("t15",  4'd15, 0, 32'h7BDEF, 5, 1'b1, 1'b0, 4'd15);
    run_search("t0",   4'd0,  0, 32'h7310,  4, 1'b1, 1'b0, 4'd0);
    run_search("t7",   4'd7,  0, 32'h7,     1, 1'b1, 1'b0, 4'd7);
    run_search("less", 4'd0,  1, 32'h7BDEF, 5, 1'b0, 1'b0, 4'd0);
    run_search("grtr", 4'd0,  2, 32'h7310,  4, 1'b0, 1'b0, 4'd0);
    run_search("illeg",4'd0,  3, 32'h7,     1, 1'b0, 1'b1, 4'd0);
    check("illeg done held", 32'(done), 32'd1);

    // Stall mid-search: one handshake, then 10 idle cycles with garbage flags and a stray start.
    target = 4'd5; mode = 0; resp_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("stall g0", 32'(guess), 32'd7);
    @(negedge clk);
    resp_valid = 1'b0; mode = 3;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    check("stall guess", 32'(guess), 32'd3);
    check("stall probes", 32'(probes), 32'd1);
    check("stall busy", 32'(busy), 32'd1);
    mode = 0; resp_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) break;
      @(negedge clk);
    end
    check("stall found", 32'(found), 32'd1);
    check("stall result", 32'(result), 32'd5);
    check("stall probes end", 32'(probes), 32'd3);

    // Reset on the third probe of a target-15 search.
    target = 4'd15; mode = 0; resp_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst pre guess", 32'(guess), 32'd13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    run_search("t9", 4'd9, 0, 32'h7B9, 3, 1'b1, 1'b0, 4'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the search space (0 to 2^WIDTH-1); legal range 2..16.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE or DONE.
REQ-005 resp_valid  input  1  responder has presented a result for the current guess.
REQ-006 less  input  1  response flag: guess < target.
REQ-007 equal  input  1  response flag: guess == target.
REQ-008 greater  input  1  response flag: guess > target.
REQ-009 guess  output  WIDTH  current probe value, presented to the responder as its A operand.
REQ-010 guess_valid  output  1  guess is stable and awaits a response.
REQ-011 busy  output  1  search in progress.
REQ-012 done  output  1  search finished; held high until the next accepted start.
REQ-013 found  output  1  qualifies done: high means equal was received and result holds the target.
REQ-014 error  output  1  qualifies done: high means an illegal response was received.
REQ-015 result  output  WIDTH  final matched value; meaningful only when done=1 and found=1.
REQ-016 probes  output  WIDTH+1  count of responses consumed in the current or last search.

Function
REQ-017 States: IDLE, PROBE, DONE; any encoding is permitted; no other reachable state is allowed.
REQ-018 Internal bounds: lo and hi, each WIDTH+1 bits unsigned; all bound arithmetic is carried out at WIDTH+1 bits, so no wrap is possible.
REQ-019 IDLE or DONE with start=1 transitions to PROBE on the next edge, with lo=0, hi=2^WIDTH-1, probes=0, done/found/error=0, busy=1.
REQ-020 In PROBE: guess=(lo+hi)>>1, truncated to WIDTH bits; guess_valid=1 throughout PROBE.
REQ-021 A handshake completes on a cycle where guess_valid=1 and resp_valid=1; probes increments by 1 on that edge.
REQ-022 The response may be combinational from guess in the same cycle; the next guess appears one cycle after the handshake.
REQ-023 A legal response has exactly one of less/equal/greater high.
REQ-024 equal: go to DONE, with result=guess, found=1.
REQ-025 less: lo=guess+1; if the new lo>hi, go to DONE with found=0, otherwise stay in PROBE.
REQ-026 greater: if guess==lo, go to DONE with found=0; otherwise hi=guess-1 and stay in PROBE.
REQ-027 Illegal response (zero flags, or two or more flags, while resp_valid=1): go to DONE with error=1, found=0; lo and hi are left unchanged.
REQ-028 resp_valid=0 in PROBE: hold all state indefinitely; flag inputs are ignored.
REQ-029 The worst-case number of probes for a legal responder is WIDTH+1.
REQ-030 start asserted while in PROBE is ignored.
REQ-031 In DONE: busy=0, guess_valid=0, done=1; result, found, error and probes are held.
REQ-032 In IDLE: busy=0, guess_valid=0, done=0.

Reset
REQ-033 rst=1 at a clock edge forces IDLE from any state, including mid-search, and overrides start and resp_valid.
REQ-034 Reset values: guess=0, guess_valid=0, busy=0, done=0, found=0, error=0, result=0, probes=0, lo=0, hi=2^WIDTH-1.
REQ-035 The first start is accepted on the first edge after rst deasserts.

Verification (WIDTH=4; responder is a comparator of guess against a fixed target, answering in the same cycle)
REQ-036 Target 15: guesses 7,11,13,14,15 -> done=1, found=1, result=15, probes=5.
REQ-037 Target 0: guesses 7,3,1,0 -> found=1, result=0, probes=4; target 7 -> found after 1 probe.
REQ-038 Responder always answers less: guesses 7,11,13,14,15 -> done=1, found=0, error=0, probes=5, with no wrap of guess.
REQ-039 Response less=1 and greater=1 on the first probe -> done=1, error=1, found=0, probes=1; responder always answers greater -> found=0 after guess 0.
REQ-040 resp_valid held low for 10 cycles mid-search -> guess and probes are unchanged; the search then completes normally.
REQ-041 rst asserted on the 3rd probe -> all outputs are at their reset values on the next cycle; a following start on target 9 -> found=1, result=9.
